// File: rtl/grostl_pkg.sv
// Shared types, MixBytes coefficients and GF(2^8) helpers for the Grostl
// MixBytes datapath.
package grostl_pkg;

   typedef logic [7:0]          byte_t;
   typedef logic [0:7][7:0]     column_t;
   typedef logic [0:7][0:7][7:0] state_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

   localparam byte_t MIX_COEF [0:7] = '{8'h02, 8'h02, 8'h03, 8'h04,
                                        8'h05, 8'h03, 8'h05, 8'h07};

   function automatic byte_t gf_xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   // Only the constants appearing in MIX_COEF are needed, so each product is
   // a couple of xtimes and XORs rather than a general multiplier.
   function automatic byte_t gf_mul_const(input byte_t a, input byte_t c);
      byte_t x2;
      byte_t x4;
      x2 = gf_xtime(a);
      x4 = gf_xtime(x2);
      case (c)
         8'h02:   return x2;
         8'h03:   return x2 ^ a;
         8'h04:   return x4;
         8'h05:   return x4 ^ a;
         8'h07:   return x4 ^ x2 ^ a;
         default: return a;
      endcase
   endfunction

endpackage

// File: rtl/grostl_mix_column.sv
// Combinational MixBytes of one 8-byte column: b[r] = XOR_j c[(j-r) mod 8] * a[j].
module grostl_mix_column
   import grostl_pkg::*;
(
   input  column_t col_i,
   output column_t col_o
);

   always_comb begin
      col_o = '0;
      for (int r = 0; r < 8; r++) begin
         for (int j = 0; j < 8; j++) begin
            col_o[r] = col_o[r] ^ gf_mul_const(col_i[j], MIX_COEF[3'(j - r)]);
         end
      end
   end

endmodule

// File: rtl/grostl_mix_bytes_serial.sv
// Column-serial Grostl MixBytes: captures a full state, mixes COLS columns per
// cycle in place, then holds the result under a valid/ready handshake.
module grostl_mix_bytes_serial
   import grostl_pkg::*;
#(
   parameter int COLS = 1
)
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   in_valid,
   output logic   in_ready,
   input  state_t din,
   output logic   out_valid,
   input  logic   out_ready,
   output state_t dout,
   output logic   busy
);

   localparam int         GROUPS   = 8 / COLS;
   localparam logic [2:0] LAST_GRP = 3'(GROUPS - 1);

   fsm_e       fsm_q, fsm_d;
   state_t     state_q, state_d;
   logic [2:0] col_cnt_q, col_cnt_d;
   logic [2:0] base;
   column_t    mixed [COLS];

   assign base = 3'(col_cnt_q * COLS);

   for (genvar k = 0; k < COLS; k++) begin : g_mix
      logic [2:0] idx;
      assign idx = base + 3'(k);
      grostl_mix_column u_mix (
         .col_i (state_q[idx]),
         .col_o (mixed[k])
      );
   end

   always_comb begin
      fsm_d     = fsm_q;
      state_d   = state_q;
      col_cnt_d = col_cnt_q;
      in_ready  = 1'b0;
      case (fsm_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d   = din;
               col_cnt_d = 3'd0;
               fsm_d     = RUN;
            end
         end
         RUN: begin
            for (int k = 0; k < COLS; k++) begin
               state_d[base + 3'(k)] = mixed[k];
            end
            if (col_cnt_q == LAST_GRP) begin
               col_cnt_d = 3'd0;
               fsm_d     = DONE;
            end else begin
               col_cnt_d = col_cnt_q + 3'd1;
            end
         end
         DONE: begin
            // The handoff cycle doubles as the next accept to keep the
            // throughput at one state per GROUPS+1 cycles.
            if (out_ready) begin
               in_ready = 1'b1;
               if (in_valid) begin
                  state_d   = din;
                  col_cnt_d = 3'd0;
                  fsm_d     = RUN;
               end else begin
                  fsm_d = IDLE;
               end
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q     <= IDLE;
         state_q   <= '0;
         col_cnt_q <= 3'd0;
      end else begin
         fsm_q     <= fsm_d;
         state_q   <= state_d;
         col_cnt_q <= col_cnt_d;
      end
   end

   assign out_valid = (fsm_q == DONE);
   assign busy      = (fsm_q == RUN);
   assign dout      = state_q;

endmodule
